// File: rtl/valu_pkg.sv
// Shared opcode encodings, FSM state type and legality check for the vector
// ALU issue/writeback sequencer.
package valu_pkg;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0000100;
    localparam logic [6:0] F7_MUL = 7'b1001011;
    localparam logic [6:0] F7_DIV = 7'b1001100;

    localparam logic [2:0] F3_OPVV = 3'b000;
    localparam logic [2:0] F3_OPVX = 3'b100;
    localparam logic [2:0] F3_OPVI = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_BAD
    } state_t;

    function automatic logic is_legal_op(input logic [6:0] funct7, input logic [2:0] funct3);
        logic f7_ok;
        logic f3_ok;
        f7_ok = (funct7 == F7_ADD) || (funct7 == F7_SUB) ||
                (funct7 == F7_MUL) || (funct7 == F7_DIV);
        f3_ok = (funct3 == F3_OPVV) || (funct3 == F3_OPVX) || (funct3 == F3_OPVI);
        return f7_ok && f3_ok;
    endfunction

endpackage

// File: rtl/valu_seq.sv
// Issue/writeback sequencer for the vector ALU: reads VRF operands, feeds the
// valu for one cycle, and writes the (zero-divisor patched) result back.
module valu_seq
    import valu_pkg::*;
#(
    parameter int VLEN       = 256,
    parameter int ELEM_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int VREG_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_funct7,
    input  logic [2:0]            in_funct3,
    input  logic [VREG_AW-1:0]    in_vs1,
    input  logic [VREG_AW-1:0]    in_vs2,
    input  logic [VREG_AW-1:0]    in_vd,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [4:0]            in_imm,
    output logic [VREG_AW-1:0]    vrf_ra1,
    output logic [VREG_AW-1:0]    vrf_ra2,
    input  logic [VLEN-1:0]       vrf_rd1,
    input  logic [VLEN-1:0]       vrf_rd2,
    output logic [VLEN-1:0]       alu_op1,
    output logic [VLEN-1:0]       alu_op2,
    output logic [ELEM_SIZE-1:0]  alu_imm,
    output logic [6:0]            alu_funct7,
    output logic [2:0]            alu_funct3,
    input  logic [VLEN-1:0]       alu_result,
    output logic                  vrf_we,
    output logic [VREG_AW-1:0]    vrf_wa,
    output logic [VLEN-1:0]       vrf_wd,
    output logic                  done,
    output logic                  err
);

    localparam int NUMELEMS = VLEN / ELEM_SIZE;

    state_t                 state;
    logic [6:0]             funct7_q;
    logic [2:0]             funct3_q;
    logic [VREG_AW-1:0]     vd_q;
    logic [ELEM_SIZE-1:0]   rs1_q;
    logic [4:0]             imm_q;
    logic [NUMELEMS-1:0]    zmask_q;
    logic [NUMELEMS-1:0]    zmask_d;
    logic [VLEN-1:0]        op2_sel;
    logic [VLEN-1:0]        wd_sel;
    logic [ELEM_SIZE-1:0]   imm_sext;
    logic                   in_exec;
    logic                   in_wb;

    assign in_exec  = (state == S_EXEC);
    assign in_wb    = (state == S_WB);
    assign imm_sext = {{(ELEM_SIZE-5){imm_q[4]}}, imm_q};

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        op2_sel = '0;
        zmask_d = '0;
        wd_sel  = '0;
        case (funct3_q)
            F3_OPVV: op2_sel = vrf_rd2;
            F3_OPVX: op2_sel = {NUMELEMS{rs1_q}};
            default: op2_sel = '0;
        endcase
        for (int i = 0; i < NUMELEMS; i++) begin
            // The effective divisor for VI is the immediate, not the zeroed op2.
            zmask_d[i] = (funct7_q == F7_DIV) &&
                         ((funct3_q == F3_OPVI) ? (imm_sext == '0)
                                                : (op2_sel[i*ELEM_SIZE +: ELEM_SIZE] == '0));
            wd_sel[i*ELEM_SIZE +: ELEM_SIZE] = zmask_q[i] ? {ELEM_SIZE{1'b1}}
                                                          : alu_result[i*ELEM_SIZE +: ELEM_SIZE];
        end
    end

    assign alu_op1    = in_exec ? vrf_rd1 : '0;
    assign alu_op2    = in_exec ? op2_sel : '0;
    assign alu_imm    = (in_exec && funct3_q == F3_OPVI) ? imm_sext : '0;
    assign alu_funct7 = in_exec ? funct7_q : '0;
    assign alu_funct3 = in_exec ? funct3_q : '0;
    assign vrf_wa     = in_wb ? vd_q : '0;
    assign vrf_wd     = in_wb ? wd_sel : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            vrf_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            vrf_ra1  <= '0;
            vrf_ra2  <= '0;
            funct7_q <= '0;
            funct3_q <= '0;
            vd_q     <= '0;
            rs1_q    <= '0;
            imm_q    <= '0;
            zmask_q  <= '0;
        end else begin
            vrf_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE, S_WB: begin
                    zmask_q <= '0;
                    if (in_valid) begin
                        funct7_q <= in_funct7;
                        funct3_q <= in_funct3;
                        vd_q     <= in_vd;
                        rs1_q    <= in_rs1_data[ELEM_SIZE-1:0];
                        imm_q    <= in_imm;
                        in_ready <= 1'b0;
                        if (is_legal_op(in_funct7, in_funct3)) begin
                            vrf_ra1 <= in_vs1;
                            vrf_ra2 <= in_vs2;
                            state   <= S_READ;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_BAD;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    zmask_q  <= zmask_d;
                    vrf_we   <= 1'b1;
                    done     <= 1'b1;
                    err      <= |zmask_d;
                    in_ready <= 1'b1;
                    state    <= S_WB;
                end
                S_BAD: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valu_seq.sv
// Bench for valu_seq: behavioural VRF and valu around the DUT, plus a
// per-instruction reference built from plain element arithmetic.
module tb_valu_seq;

    localparam int VLEN = 256;
    localparam int ES   = 32;
    localparam int NE   = VLEN / ES;
    localparam int AW   = 5;

    typedef logic [VLEN-1:0] vec_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [6:0]     in_funct7;
    logic [2:0]     in_funct3;
    logic [AW-1:0]  in_vs1, in_vs2, in_vd;
    logic [31:0]    in_rs1_data;
    logic [4:0]     in_imm;
    logic [AW-1:0]  vrf_ra1, vrf_ra2;
    vec_t           vrf_rd1, vrf_rd2;
    vec_t           alu_op1, alu_op2;
    logic [ES-1:0]  alu_imm;
    logic [6:0]     alu_funct7;
    logic [2:0]     alu_funct3;
    vec_t           alu_result;
    logic           vrf_we;
    logic [AW-1:0]  vrf_wa;
    vec_t           vrf_wd;
    logic           done;
    logic           err;

    logic           tb_we;
    logic [AW-1:0]  tb_wa;
    vec_t           tb_wd;

    vec_t           vrf [32];
    vec_t           ref_vrf [32];
    int             vectors = 0;
    int             miscompares = 0;
    int             wr_count = 0;
    int             legal_count = 0;

    valu_seq #(.VLEN(VLEN), .ELEM_SIZE(ES), .DATA_WIDTH(32), .VREG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct7(in_funct7), .in_funct3(in_funct3),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
        .in_rs1_data(in_rs1_data), .in_imm(in_imm),
        .vrf_ra1(vrf_ra1), .vrf_ra2(vrf_ra2),
        .vrf_rd1(vrf_rd1), .vrf_rd2(vrf_rd2),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm),
        .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
        .alu_result(alu_result),
        .vrf_we(vrf_we), .vrf_wa(vrf_wa), .vrf_wd(vrf_wd),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External valu: registered, element-wise; its own divide-by-zero answer is 0.
    function automatic vec_t valu_fn(input vec_t a, input vec_t b, input logic [ES-1:0] imm,
                                     input logic [6:0] f7, input logic [2:0] f3);
        vec_t r = '0;
        for (int i = 0; i < NE; i++) begin
            logic [ES-1:0] x, y;
            x = a[i*ES +: ES];
            y = (f3 == 3'b011) ? imm : b[i*ES +: ES];
            case (f7)
                7'b0000000: r[i*ES +: ES] = x + y;
                7'b0000100: r[i*ES +: ES] = x - y;
                7'b1001011: r[i*ES +: ES] = x * y;
                7'b1001100: r[i*ES +: ES] = (y == 0) ? '0 : x / y;
                default:    r[i*ES +: ES] = '0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        vrf_rd1    <= vrf[vrf_ra1];
        vrf_rd2    <= vrf[vrf_ra2];
        alu_result <= valu_fn(alu_op1, alu_op2, alu_imm, alu_funct7, alu_funct3);
        if (vrf_we) begin
            vrf[vrf_wa] <= vrf_wd;
            wr_count    <= wr_count + 1;
        end else if (tb_we) begin
            vrf[tb_wa] <= tb_wd;
        end
    end

    // Architectural result of one instruction; divide-by-zero lanes read as all ones.
    function automatic vec_t ref_calc(input logic [6:0] f7, input logic [2:0] f3,
                                      input vec_t a, input vec_t b, input logic [31:0] rs1,
                                      input logic [4:0] imm, output logic e);
        vec_t r = '0;
        e = 1'b0;
        for (int i = 0; i < NE; i++) begin
            logic [31:0] x, y;
            x = a[i*ES +: ES];
            if (f3 == 3'b000)      y = b[i*ES +: ES];
            else if (f3 == 3'b100) y = rs1;
            else                   y = {{27{imm[4]}}, imm};
            if (f7 == 7'b0000000)      r[i*ES +: ES] = x + y;
            else if (f7 == 7'b0000100) r[i*ES +: ES] = x - y;
            else if (f7 == 7'b1001011) r[i*ES +: ES] = x * y;
            else if (y == 0) begin
                r[i*ES +: ES] = 32'hFFFF_FFFF;
                e = 1'b1;
            end else r[i*ES +: ES] = x / y;
        end
        return r;
    endfunction

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_reg(input int idx, input vec_t val);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = AW'(idx);
        tb_wd = val;
        @(posedge clk);
        #1 tb_we = 1'b0;
        ref_vrf[idx] = val;
    endtask

    // Issues one instruction and follows it to completion; returns in BAD or WB.
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input int vs1, input int vs2,
                         input int vd, input logic [31:0] rs1, input logic [4:0] imm,
                         input bit hold_valid);
        int   guard = 0;
        bit   legal;
        logic exp_err;
        vec_t exp_wd, exp_op2;
        logic [ES-1:0] exp_imm;
        while (!in_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", vec_t'(in_ready), vec_t'(1'b1));
        legal = (f7 == 7'b0000000 || f7 == 7'b0000100 || f7 == 7'b1001011 || f7 == 7'b1001100) &&
                (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011);
        exp_wd  = ref_calc(f7, f3, ref_vrf[vs1], ref_vrf[vs2], rs1, imm, exp_err);
        exp_op2 = (f3 == 3'b000) ? ref_vrf[vs2] : (f3 == 3'b100) ? {NE{rs1}} : '0;
        exp_imm = (f3 == 3'b011) ? {{27{imm[4]}}, imm} : '0;
        in_valid = 1'b1;
        in_funct7 = f7; in_funct3 = f3;
        in_vs1 = AW'(vs1); in_vs2 = AW'(vs2); in_vd = AW'(vd);
        in_rs1_data = rs1; in_imm = imm;
        @(posedge clk);
        @(negedge clk);
        in_valid = hold_valid;
        in_funct7 = 7'($urandom); in_funct3 = 3'($urandom);
        in_vs1 = AW'($urandom); in_vs2 = AW'($urandom); in_vd = AW'($urandom);
        in_rs1_data = $urandom; in_imm = 5'($urandom);
        if (!legal) begin
            check("bad_done", vec_t'(done), vec_t'(1'b1));
            check("bad_err", vec_t'(err), vec_t'(1'b1));
            check("bad_we", vec_t'(vrf_we), vec_t'(1'b0));
            check("bad_ready", vec_t'(in_ready), vec_t'(1'b0));
            in_valid = 1'b0;
            return;
        end
        check("read_ready", vec_t'(in_ready), vec_t'(1'b0));
        check("read_ra1", vec_t'(vrf_ra1), vec_t'(vs1));
        check("read_ra2", vec_t'(vrf_ra2), vec_t'(vs2));
        check("read_done", vec_t'(done), vec_t'(1'b0));
        @(negedge clk);
        check("exec_op1", alu_op1, ref_vrf[vs1]);
        check("exec_op2", alu_op2, exp_op2);
        check("exec_imm", vec_t'(alu_imm), vec_t'(exp_imm));
        check("exec_f7f3", vec_t'({alu_funct7, alu_funct3}), vec_t'({f7, f3}));
        check("exec_we", vec_t'(vrf_we), vec_t'(1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        check("wb_we", vec_t'(vrf_we), vec_t'(1'b1));
        check("wb_wa", vec_t'(vrf_wa), vec_t'(vd));
        check("wb_wd", vrf_wd, exp_wd);
        check("wb_done", vec_t'(done), vec_t'(1'b1));
        check("wb_err", vec_t'(err), vec_t'(exp_err));
        check("wb_ready", vec_t'(in_ready), vec_t'(1'b1));
        ref_vrf[vd] = exp_wd;
        legal_count++;
    endtask

    function automatic vec_t splat(input logic [31:0] v);
        return {NE{v}};
    endfunction

    initial begin
        int   w0;
        vec_t rv;
        logic [6:0] f7_tab [4];
        logic [2:0] f3_tab [3];
        f7_tab = '{7'b0000000, 7'b0000100, 7'b1001011, 7'b1001100};
        f3_tab = '{3'b000, 3'b100, 3'b011};
        rst_n = 1'b0; in_valid = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        in_funct7 = '0; in_funct3 = '0; in_vs1 = '0; in_vs2 = '0; in_vd = '0;
        in_rs1_data = '0; in_imm = '0;
        #12;
        check("rst_ready", vec_t'(in_ready), vec_t'(1'b1));
        check("rst_we_done_err", vec_t'({vrf_we, done, err}), vec_t'(3'b000));
        check("rst_addr", vec_t'({vrf_ra1, vrf_ra2, vrf_wa}), '0);
        check("rst_ops", alu_op1 | alu_op2 | vec_t'(alu_imm) | vec_t'({alu_funct7, alu_funct3}), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 32; r++) begin
            for (int e = 0; e < NE; e++)
                rv[e*ES +: ES] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            load_reg(r, rv);
        end

        // VV ADD: 5 + 7
        load_reg(2, splat(32'd5));
        load_reg(3, splat(32'd7));
        issue(7'b0000000, 3'b000, 2, 3, 4, 32'd0, 5'd0, 1'b0);
        check("vv_add_const", vrf_wd, splat(32'd12));

        // VX SUB: 100 - 30, with in_valid held through the busy cycles
        load_reg(2, splat(32'd100));
        issue(7'b0000100, 3'b100, 2, 7, 5, 32'd30, 5'd0, 1'b1);
        check("vx_sub_const", vrf_wd, splat(32'd70));

        // VI ADD: 10 + (-2)
        load_reg(2, splat(32'd10));
        issue(7'b0000000, 3'b011, 2, 9, 6, 32'd0, 5'b11110, 1'b0);
        check("vi_add_const", vrf_wd, splat(32'd8));

        // DIV with zero divisors in lanes 0 and 7
        load_reg(2, splat(32'd40));
        load_reg(3, {32'd0, {6{32'd4}}, 32'd0});
        issue(7'b1001100, 3'b000, 2, 3, 8, 32'd0, 5'd0, 1'b0);
        check("div0_const", vrf_wd, {32'hFFFF_FFFF, {6{32'd10}}, 32'hFFFF_FFFF});
        check("div0_err", vec_t'(err), vec_t'(1'b1));

        // Illegal funct7, then illegal funct3, then two back-to-back ADDs
        @(negedge clk);
        w0 = wr_count;
        issue(7'b0111111, 3'b000, 1, 2, 10, 32'd0, 5'd0, 1'b0);
        issue(7'b0000000, 3'b001, 1, 2, 11, 32'd0, 5'd0, 1'b0);
        issue(7'b0000000, 3'b000, 4, 5, 12, 32'd0, 5'd0, 1'b0);
        issue(7'b0000000, 3'b000, 12, 12, 13, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("illegal_no_write", vec_t'(wr_count - w0), vec_t'(2));
        check("raw_result", vrf[13], ref_vrf[13]);

        // Reset in the middle of EXEC abandons the instruction
        w0 = wr_count;
        in_valid = 1'b1; in_funct7 = 7'b0000000; in_funct3 = 3'b000;
        in_vs1 = 5'd4; in_vs2 = 5'd4; in_vd = 5'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_we", vec_t'(vrf_we), vec_t'(1'b0));
        check("midrst_ready", vec_t'(in_ready), vec_t'(1'b1));
        check("midrst_done", vec_t'(done), vec_t'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_write", vec_t'(wr_count - w0), vec_t'(0));
        check("midrst_vd_intact", vrf[20], ref_vrf[20]);

        // Randomized mix, including illegal ops and back-to-back issue
        for (int n = 0; n < 80; n++) begin
            logic [6:0] f7;
            logic [2:0] f3;
            int sel;
            sel = $urandom_range(0, 9);
            f7 = f7_tab[$urandom_range(0, 3)];
            f3 = f3_tab[$urandom_range(0, 2)];
            if (sel == 0) f7 = 7'b1111111 ^ 7'($urandom_range(0, 63));
            if (sel == 1) f3 = 3'b111;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(f7, f3, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        check("total_writes", vec_t'(wr_count), vec_t'(legal_count));
        for (int r = 0; r < 32; r += 5)
            check($sformatf("final_v%0d", r), vrf[r], ref_vrf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
